// File: rtl/baud_pkg.sv
// Shared constants and types for the baud tick generator.
// Optional feature macro: BAUD_FRAC_EN (fractional divisor).
package baud_pkg;

    localparam int unsigned BAUD_DIV_W_DEF  = 16;
    localparam int unsigned BAUD_OVS_DEF    = 16;
    localparam int unsigned BAUD_FRAC_W_DEF = 4;

    // Divisor word at the default width.
    typedef logic [BAUD_DIV_W_DEF-1:0] baud_div_t;

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control/status bundle between the UART register file and the baud generator.
// Optional feature macro: BAUD_FRAC_EN adds the frac_in field.
interface baud_tick_gen_if
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W = BAUD_DIV_W_DEF
`ifdef BAUD_FRAC_EN
    ,
    parameter int unsigned FRAC_W = BAUD_FRAC_W_DEF
`endif
);

    logic             en;
    logic             div_wr;
    logic [DIV_W-1:0] div_in;
`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_in;
`endif
    logic             sync_clr;
    logic [DIV_W-1:0] div_out;
    logic             rdy;
    logic             rx_tick;
    logic             tx_tick;

    // Register file side: drives control, observes status and ticks.
    modport master (
        output en,
        output div_wr,
        output div_in,
`ifdef BAUD_FRAC_EN
        output frac_in,
`endif
        output sync_clr,
        input  div_out,
        input  rdy,
        input  rx_tick,
        input  tx_tick
    );

    // Generator side.
    modport slave (
        input  en,
        input  div_wr,
        input  div_in,
`ifdef BAUD_FRAC_EN
        input  frac_in,
`endif
        input  sync_clr,
        output div_out,
        output rdy,
        output rx_tick,
        output tx_tick
    );

endinterface

// File: rtl/mod_counter.sv
// Generic modulo-N up-counter with enable and clear; at_wrap_c flags the last count.
module mod_counter #(
    parameter int unsigned N = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic at_wrap_c
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at N-1 rather than at 2^W.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_wrap_c = (cnt_q == LAST);

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: rx_tick every div+1 clocks, tx_tick every OVS rx_ticks.
// Optional feature macro: BAUD_FRAC_EN (fractional divisor via phase accumulator).
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W = BAUD_DIV_W_DEF,
    parameter int unsigned OVS   = BAUD_OVS_DEF
`ifdef BAUD_FRAC_EN
    ,
    parameter int unsigned FRAC_W = BAUD_FRAC_W_DEF
`endif
) (
    input  logic           clk,
    input  logic           rst,
    baud_tick_gen_if.slave bus
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;
    logic             rx_tick_q, rx_tick_d;
    logic             tx_tick_q, tx_tick_d;
    logic             ovs_en;
    logic             ovs_clr;
    logic             ovs_wrap_c;
`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic [FRAC_W:0]   frac_sum;
`endif
    logic             reload_extra;

`ifdef BAUD_FRAC_EN
    // Carry out of the accumulator stretches the next period by one clock.
    assign frac_sum     = {1'b0, frac_acc_q} + {1'b0, frac_q};
    assign reload_extra = frac_sum[FRAC_W];
`else
    assign reload_extra = 1'b0;
`endif

    // Next-state: div_wr > sync_clr > hold (not ready / disabled) > count.
    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        rdy_d     = rdy_q;
        rx_tick_d = 1'b0;
        tx_tick_d = 1'b0;
        ovs_en    = 1'b0;
        ovs_clr   = 1'b0;
`ifdef BAUD_FRAC_EN
        frac_d     = frac_q;
        frac_acc_d = frac_acc_q;
`endif
        if (bus.div_wr) begin
            div_d   = bus.div_in;
            cnt_d   = bus.div_in;
            rdy_d   = 1'b1;
            ovs_clr = 1'b1;
`ifdef BAUD_FRAC_EN
            frac_d     = bus.frac_in;
            frac_acc_d = '0;
`endif
        end else if (bus.sync_clr && rdy_q) begin
            cnt_d   = div_q;
            ovs_clr = 1'b1;
`ifdef BAUD_FRAC_EN
            frac_acc_d = '0;
`endif
        end else if (rdy_q && bus.en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DIV_W'(1);
            end else begin
                rx_tick_d = 1'b1;
                tx_tick_d = ovs_wrap_c;
                ovs_en    = 1'b1;
                cnt_d     = div_q + DIV_W'(reload_extra);
`ifdef BAUD_FRAC_EN
                frac_acc_d = frac_sum[FRAC_W-1:0];
`endif
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            rx_tick_q <= 1'b0;
            tx_tick_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            rx_tick_q <= rx_tick_d;
            tx_tick_q <= tx_tick_d;
        end
    end

`ifdef BAUD_FRAC_EN
    // Fractional divisor and phase accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frac_q     <= '0;
            frac_acc_q <= '0;
        end else begin
            frac_q     <= frac_d;
            frac_acc_q <= frac_acc_d;
        end
    end
`endif

    // Oversample counter: counts rx_ticks, flags the OVS-th one.
    mod_counter #(
        .N (OVS)
    ) u_ovs_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (ovs_en),
        .clr       (ovs_clr),
        .at_wrap_c (ovs_wrap_c)
    );

    assign bus.div_out = div_q;
    assign bus.rdy     = rdy_q;
    assign bus.rx_tick = rx_tick_q;
    assign bus.tx_tick = tx_tick_q;

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
Parametrised successor to the 16-bit baud down-counter. It generates a receive oversample tick (rx_tick) every DIV+1 clocks and a transmit bit tick (tx_tick) every OVS rx_ticks. It adds run enable, phase resynchronisation for RX start-bit alignment, a readable divisor, and optional fractional division. It sits between the UART register file (divisor writes) and the RX/TX shifters.

Parameters:
DIV_W, 16, divisor/counter width in bits (4..32)
OVS, 16, oversample ratio (rx_ticks per tx_tick), 2..256
FRAC_W, 4, fractional divisor width (used only with BAUD_FRAC_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset (0 = reset asserted, released synchronously by the integrator)
en  in  1  run enable; 0 freezes counters and forces ticks low
div_wr  in  1  one-cycle strobe, loads div_in into the divisor register
div_in  in  DIV_W  divisor value; rx period = div_in+1 clocks
frac_in  in  FRAC_W  fractional divisor, sampled with div_wr (BAUD_FRAC_EN only)
sync_clr  in  1  restart tick phase without changing the divisor
div_out  out  DIV_W  current divisor register
rdy  out  1  high once a divisor has been loaded since reset
rx_tick  out  1  registered one-cycle oversample tick
tx_tick  out  1  registered one-cycle bit tick, coincident with an rx_tick

Behaviour:
- Reset (rst=0, async): div_q=0, cnt=0, ovs_cnt=0, rdy=0, rx_tick=0, tx_tick=0, div_out=0, frac_acc=0.
- Per-cycle priority: div_wr > sync_clr > (!rdy or !en) > count.
- div_wr: div_q<=div_in, cnt<=div_in, ovs_cnt<=0, rdy<=1, ticks 0 this cycle. Allowed at any time, including mid-count. It restarts phase.
- sync_clr (rdy=1): cnt<=div_q, ovs_cnt<=0, frac_acc<=0, ticks 0. div_q unchanged. With rdy=0 it is ignored.
- rdy=0 or en=0: counters hold and rx_tick=tx_tick=0. en low does not clear phase, so counting resumes exactly where it stopped.
- Count state (rdy=1, en=1):
  - cnt!=0: cnt<=cnt-1, ticks 0.
  - cnt==0: rx_tick<=1 next cycle and cnt<=div_q.
    - If ovs_cnt==OVS-1: ovs_cnt<=0 and tx_tick<=1 with the same rx_tick.
    - Otherwise ovs_cnt<=ovs_cnt+1.
- Latency: first rx_tick is asserted div_in+1 cycles after the div_wr cycle. The first tx_tick occurs on the OVS-th rx_tick.
- div_q=0: rx_tick high every cycle while en=1. tx_tick high one cycle in every OVS cycles.
- Widths: cnt is DIV_W bits and never underflows (reload at 0). ovs_cnt is $clog2(OVS) bits, with wrap at OVS-1 (not a power-of-2 wrap).
- div_out = div_q, registered.
- Reset asserted mid-count: everything clears immediately and rdy must be re-established by div_wr.

Optional Feature:
BAUD_FRAC_EN
- Defined: frac_in port exists. frac_q is loaded with div_wr. At each cnt==0 event: frac_acc<=frac_acc+frac_q (FRAC_W bits).
  - On carry-out, the reload value is div_q+1 instead of div_q, so that period is one clock longer.
  - Average rx period = div_q+1+frac_q/2^FRAC_W.
  - frac_acc clears on div_wr and sync_clr.
- Undefined: no frac_in port, no accumulator, fixed period div_q+1.

Decomposition:
- Package baud_pkg holds:
  - default constants: BAUD_DIV_W_DEF=16, BAUD_OVS_DEF=16, BAUD_FRAC_W_DEF=4
  - typedef for the divisor word
- One natural sub-module: mod_counter, a generic modulo-N up-counter with enable, clear and wrap pulse, used for ovs_cnt.
- The down-counter and reload logic stay in the top.

Test Plan:
1. Reset, then div_wr with div_in=3, OVS=16, en=1:
   - rx_tick every 4 clocks, first 4 cycles after the strobe.
   - tx_tick every 64 clocks, aligned with the 16th rx_tick.
   - rdy=1, div_out=3.
2. No div_wr after reset with en=1 for 100 cycles -> rx_tick=tx_tick=0 and rdy=0 throughout.
3. div_in=0 -> rx_tick continuously high. tx_tick is high 1 of every 16 cycles.
4. div_in=9:
   - Drop en for 7 cycles mid-period -> no ticks while en=0, and the next rx_tick is delayed by exactly 7 cycles.
   - sync_clr after the 5th rx_tick -> next rx_tick 10 cycles later, and tx_tick after 16 further rx_ticks.
5. Issue div_wr with div_in=1 while running with div_in=100 and ovs_cnt=7 -> old count is abandoned, rx_tick 2 cycles later, and tx_tick after 16 new rx_ticks.
6. BAUD_FRAC_EN, div_in=4, frac_in=8 (FRAC_W=4) -> rx periods alternate 5,6,5,6 clocks. Assert rst mid-period -> all outputs 0 immediately.
